// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Types and constants shared by the data-memory responder and
//               its RAM: the responder FSM states, the load/store opcodes,
//               the datapath word width and the latency-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;    // wide enough for LATENCY-1 up to 14

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

  // Word accesses only: both low address bits must be zero.
  function automatic logic is_word_aligned(input logic [1:0] byte_off);
    return (byte_off == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module      : data_ram
// Description : Single-port synchronous word RAM, 2^ADDR_WIDTH deep, with a
//               registered read port (read-before-write on the same edge).
//               Contents are not reset.
// Ports       : clk_i   - rising-edge clock
//               we_i    - write enable
//               addr_i  - word address
//               wdata_i - write data
//               rdata_o - registered read data for the address of the
//                         previous cycle
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Multi-cycle data-memory responder. Latches a load/store
//               request, waits LATENCY cycles, commits the word access to
//               the internal RAM and holds the processor with Stall until
//               the access completes. Faulting requests (both strobes high,
//               or a misaligned address) are dropped and raise a sticky
//               Error flag.
// Ports       : Clock_i     - rising-edge clock
//               Reset_i     - asynchronous active-high reset
//               MemRead_i   - load request
//               MemWrite_i  - store request
//               Address_i   - byte address (ALU result)
//               WriteData_i - store data
//               ReadData_o  - registered load data, held between loads
//               Stall_o     - freeze PC/pipeline while high
//               Done_o      - one-cycle completion pulse
//               Error_o     - sticky request-fault flag
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic              Clock_i,
  input  logic              Reset_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [WORD_W-1:0] Address_i,
  input  logic [WORD_W-1:0] WriteData_i,
  output logic [WORD_W-1:0] ReadData_o,
  output logic              Stall_o,
  output logic              Done_o,
  output logic              Error_o
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_ctrl: LATENCY must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_e            state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  stall_d;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WORD_W-1:0]     ram_rdata;

  // Upper address bits are deliberately dropped so addresses wrap.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^Address_i[WORD_W-1:ADDR_WIDTH+2];

  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  req_any;
  logic                  req_conflict;
  logic                  req_misalign;
  logic                  req_valid;

  assign req_idx      = Address_i[ADDR_WIDTH+1:2];
  assign req_any      = MemRead_i | MemWrite_i;
  assign req_conflict = MemRead_i & MemWrite_i;
  assign req_misalign = req_any & ~is_word_aligned(Address_i[1:0]);
  assign req_valid    = (MemRead_i ^ MemWrite_i) & is_word_aligned(Address_i[1:0]);

  // The RAM follows the live address while idle so that its registered read
  // port already holds the target word one cycle after the request. That
  // word then stays valid through ACCESS because the latched index is used,
  // which lets a load commit after only one ACCESS cycle when LATENCY is 1.
  assign ram_addr = (state_q == IDLE) ? req_idx : idx_q;

  data_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_data_ram (
    .clk_i   (Clock_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    stall_d    = 1'b0;
    ram_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall_d    = 1'b1;
          is_store_d = MemWrite_i;
          idx_d      = req_idx;
          wdata_d    = WriteData_i;
          cnt_d      = CNT_LOAD;
          state_d    = ACCESS;
        end else if (req_conflict || req_misalign) begin
          err_d = 1'b1;
        end
      end

      ACCESS: begin
        stall_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (is_store_q) begin
            ram_we = 1'b1;
          end else begin
            rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall decodes live inputs in IDLE, so it must be masked while the
  // asynchronous reset is held.
  assign Stall_o    = stall_d & ~Reset_i;
  assign Done_o     = (state_q == DONE);
  assign Error_o    = err_q;
  assign ReadData_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Directed self-checking bench for data_mem_ctrl with
//               LATENCY=2, ADDR_WIDTH=8. Cycle c=0 is the cycle in which a
//               request is first visible; outputs are sampled on the falling
//               edge, inputs change 1 time unit after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] ReadData;
  logic        Stall, Done, Error;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl #(
    .ADDR_WIDTH (8),
    .LATENCY    (2)
  ) dut (
    .Clock_i     (clk),
    .Reset_i     (rst),
    .MemRead_i   (rd),
    .MemWrite_i  (wr),
    .Address_i   (addr),
    .WriteData_i (wdata),
    .ReadData_o  (ReadData),
    .Stall_o     (Stall),
    .Done_o      (Done),
    .Error_o     (Error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
  endtask

  task automatic pulse_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    drive(1'b0, 1'b1, 32'h10, 32'h55);
    @(negedge clk);
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", Stall); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", ReadData); end
    checks++; if (Error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", Error); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_store();
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (Stall !== (c <= 2)) begin errors++; $display("FAIL store_stall c%0d: got %b expected %b", c, Stall, (c <= 2)); end
      checks++; if (Done !== (c == 3)) begin errors++; $display("FAIL store_done c%0d: got %b expected %b", c, Done, (c == 3)); end
      checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL store_rdata c%0d: got %h expected 0", c, ReadData); end
      checks++; if (Error !== 1'b0) begin errors++; $display("FAIL store_error c%0d: got %b expected 0", c, Error); end
      step();
      if (c == 0) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_load();
    logic [31:0] exp;
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 7; c++) begin
      exp = (c >= 3) ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
      checks++; if (Stall !== (c <= 2)) begin errors++; $display("FAIL load_stall c%0d: got %b expected %b", c, Stall, (c <= 2)); end
      checks++; if (Done !== (c == 3)) begin errors++; $display("FAIL load_done c%0d: got %b expected %b", c, Done, (c == 3)); end
      checks++; if (ReadData !== exp) begin errors++; $display("FAIL load_rdata c%0d: got %h expected %h", c, ReadData, exp); end
      step();
      if (c == 0) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] exp;
    pulse_reset();
    drive(1'b1, 1'b0, 32'h12, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL misal_stall c%0d: got %b expected 0", c, Stall); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL misal_done c%0d: got %b expected 0", c, Done); end
      checks++; if (Error !== (c >= 1)) begin errors++; $display("FAIL misal_error c%0d: got %b expected %b", c, Error, (c >= 1)); end
      step();
      if (c == 1) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 5; c++) begin
      exp = (c >= 3) ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
      checks++; if (Done !== (c == 3)) begin errors++; $display("FAIL misal_lw_done c%0d: got %b expected %b", c, Done, (c == 3)); end
      checks++; if (ReadData !== exp) begin errors++; $display("FAIL misal_lw_rdata c%0d: got %h expected %h", c, ReadData, exp); end
      checks++; if (Error !== 1'b1) begin errors++; $display("FAIL misal_lw_error c%0d: got %b expected 1", c, Error); end
      step();
      if (c == 0) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] exp;
    pulse_reset();
    drive(1'b1, 1'b1, 32'h10, 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL conf_stall c%0d: got %b expected 0", c, Stall); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL conf_done c%0d: got %b expected 0", c, Done); end
      checks++; if (Error !== (c >= 1)) begin errors++; $display("FAIL conf_error c%0d: got %b expected %b", c, Error, (c >= 1)); end
      step();
      if (c == 0) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 5; c++) begin
      exp = (c >= 3) ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
      checks++; if (ReadData !== exp) begin errors++; $display("FAIL conf_lw_rdata c%0d: got %h expected %h", c, ReadData, exp); end
      checks++; if (Error !== 1'b1) begin errors++; $display("FAIL conf_lw_error c%0d: got %b expected 1", c, Error); end
      step();
      if (c == 0) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_reset_mid_store();
    // Preload word 0x20 with zero; ReadData keeps the previous load value.
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (Done !== (c == 3)) begin errors++; $display("FAIL pre_done c%0d: got %b expected %b", c, Done, (c == 3)); end
      checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_rdata c%0d: got %h expected deadbeef", c, ReadData); end
      step();
      if (c == 0) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
    drive(1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL midrst_stall_c0: got %b expected 1", Stall); end
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b expected 0", Stall); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", Done); end
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h expected 0", ReadData); end
    checks++; if (Error !== 1'b0) begin errors++; $display("FAIL midrst_error: got %b expected 0", Error); end
    step();
    rst = 1'b0;
    step();
    step();
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (Done !== (c == 3)) begin errors++; $display("FAIL midrst_lw_done c%0d: got %b expected %b", c, Done, (c == 3)); end
      checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL midrst_lw_rdata c%0d: got %h expected 0", c, ReadData); end
      step();
      if (c == 0) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    drive(1'b0, 1'b1, 32'h400, 32'h12345678);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (Done !== (c == 3)) begin errors++; $display("FAIL wrap_sw_done c%0d: got %b expected %b", c, Done, (c == 3)); end
      step();
      if (c == 0) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h000, 32'h0);
    for (int c = 0; c < 5; c++) begin
      exp = (c >= 3) ? 32'h12345678 : 32'h0;
      @(negedge clk);
      checks++; if (Done !== (c == 3)) begin errors++; $display("FAIL wrap_lw_done c%0d: got %b expected %b", c, Done, (c == 3)); end
      checks++; if (ReadData !== exp) begin errors++; $display("FAIL wrap_lw_rdata c%0d: got %h expected %h", c, ReadData, exp); end
      step();
      if (c == 0) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    logic        exp_stall, exp_done;
    // Load held continuously: each access costs LATENCY+2 = 4 cycles.
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 10; c++) begin
      exp       = (c >= 3) ? 32'hDEADBEEF : 32'h12345678;
      exp_done  = (c == 3) || (c == 7);
      exp_stall = (c <= 7) && !exp_done;
      @(negedge clk);
      checks++; if (Stall !== exp_stall) begin errors++; $display("FAIL b2b_stall c%0d: got %b expected %b", c, Stall, exp_stall); end
      checks++; if (Done !== exp_done) begin errors++; $display("FAIL b2b_done c%0d: got %b expected %b", c, Done, exp_done); end
      checks++; if (ReadData !== exp) begin errors++; $display("FAIL b2b_rdata c%0d: got %h expected %h", c, ReadData, exp); end
      step();
      if (c == 7) drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_conflict();
    test_reset_mid_store();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle data-memory responder serving the load/store requests that the main control decoder raises on MemRead/MemWrite. It latches the datapath's byte address and store data, performs a word access to an internal synchronous RAM after a configurable latency, and holds the processor with Stall until the access completes. It sits between the ALU result/register-file read port and the MemToReg write-back mux.

## Interface

- ADDR_WIDTH, 8: word-address bits; RAM depth is 2^ADDR_WIDTH words.
- LATENCY, 2: access wait cycles; legal range is 1..15.
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- MemRead  in  1  load request from the control decoder
- MemWrite  in  1  store request from the control decoder
- Address  in  32  byte address (ALU result)
- WriteData  in  32  store data (register-file read port 2)
- ReadData  out  32  load data, registered and held between loads
- Stall  out  1  freeze PC/pipeline while high
- Done  out  1  one-cycle pulse on access completion
- Error  out  1  sticky request-fault flag

## Operation

- FSM states:
  - IDLE
    - Valid request = exactly one of MemRead/MemWrite high, and Address[1:0]==0.
    - On a valid request: latch op, word index Address[ADDR_WIDTH+1:2], and WriteData; load the counter with LATENCY-1; go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS
    - Counter decrements each cycle.
    - When the counter is 0: commit the access and go to DONE.
      - Store: write the RAM.
      - Load: register the RAM word into ReadData.
  - DONE
    - Unconditionally return to IDLE.
    - No request is sampled in DONE.
- Stall = (IDLE and valid request) or ACCESS. Stall is combinational from the inputs in IDLE. Stall is low in DONE.
- Done = 1 only in DONE.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo the RAM size.
- Error is set, and the request is ignored (no Stall, no RAM change), when in IDLE:
  - MemRead and MemWrite are both high, or
  - a request is present with Address[1:0]!=0.
- Error clears only on Reset.
- ReadData changes only at a load commit. Stores never alter ReadData.

## Timing

- Reset values: state IDLE, counter 0, ReadData 0, Done 0, Error 0. Stall is 0 while Reset is high. RAM contents are not reset.
- Request visible in cycle 0:
  - Stall is high in cycles 0..LATENCY.
  - ACCESS occupies cycles 1..LATENCY.
  - Commit happens at the end of cycle LATENCY.
  - DONE is in cycle LATENCY+1, with Done=1 and load data valid.
- Total stall per memory instruction is LATENCY+1 cycles.
- The PC advances on the edge ending DONE. The next instruction's request is sampled in the following IDLE cycle.
- Back-to-back memory instructions cost LATENCY+2 cycles each.
- Request inputs change during ACCESS: ignored, because the latched values are used.
- Reset asserted mid-ACCESS: FSM returns to IDLE immediately. An uncommitted store is dropped and ReadData is cleared.
- Error is registered: it rises in cycle 1 after a faulting request in cycle 0.

## Structure

- Shared package mips_pkg holds:
  - FSM state enum (IDLE, ACCESS, DONE)
  - OP_LW (6'b100011) and OP_SW (6'b101011) constants
  - WORD_W = 32
- Sub-module data_ram: single-port synchronous RAM with parameter ADDR_WIDTH, write enable, and registered read. It is instantiated once. The FSM and counter stay in data_mem_ctrl.

## Test plan

All scenarios use LATENCY=2 and ADDR_WIDTH=8.

- Store: reset, then MemWrite with Address=0x10, WriteData=0xDEADBEEF.
  - Stall=1 in cycles 0–2, Done=1 in cycle 3.
  - ReadData stays 0, Error stays 0.
- Load after store: MemRead with Address=0x10.
  - Stall in cycles 0–2.
  - In cycle 3, Done=1 and ReadData=0xDEADBEEF.
  - ReadData holds through following idle cycles.
- Misaligned load: MemRead with Address=0x12.
  - Stall stays 0 and Done never pulses.
  - Error=1 from cycle 1.
  - A later LW 0x10 still returns 0xDEADBEEF with Error still 1.
- Conflicting request: MemRead=MemWrite=1 with Address=0x10, WriteData=0x1.
  - Error=1, no Stall.
  - A following LW 0x10 returns 0xDEADBEEF.
- Reset mid-store: SW 0x20 with 0xCAFEF00D, Reset pulsed in cycle 1.
  - Outputs go to reset values immediately.
  - A subsequent LW 0x20 returns the prior contents (preload 0x0), not 0xCAFEF00D.
- Wrap-around: SW Address=0x400 with 0x12345678, then LW Address=0x000.
  - ReadData=0x12345678 in the load's DONE cycle.
